// File: rtl/spi_cmd_regs.sv
// Command decoder and 8-bit register bank behind a byte-level SPI slave.
// A frame is a command byte {rw, addr[6:0]} followed by data bytes, with address auto-increment.
module spi_cmd_regs #(
    parameter int NREGS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               ss,
    input  logic [7:0]         rx_data,
    input  logic               rx_rdy,
    output logic [7:0]         tx_data,
    output logic               tx_latch,
    output logic [NREGS*8-1:0] reg_out,
    output logic               wr_strobe,
    output logic [6:0]         wr_addr,
    output logic               addr_err,
    input  logic               err_clr,
    output logic [1:0]         dbg_state_o
);

    // Handshake: rx_rdy is a level, one byte per rising edge of its synchronised copy;
    // tx_latch and wr_strobe are single-cycle pulses with no back-pressure.
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;

    localparam logic [7:0] NREGS_W = 8'(NREGS);

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   ss_sync_q, rdy_sync_q, fill_q;
    logic                     rdy_s_dly_q, armed_q;
    logic [6:0]               addr_ptr_q, wr_pend_addr_q, wr_addr_q;
    logic [NREGS*8-1:0]       regs_q;
    logic [7:0]               tx_data_q;
    logic                     tx_latch_q, lat_pend_q, wr_strobe_q, wr_pend_q, addr_err_q;

    logic       ss_s, rdy_s, byte_evt, in_range, err_set;
    logic [6:0] sel_addr;
    logic [7:0] rd_byte;

    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];
    assign byte_evt = rdy_s & ~rdy_s_dly_q;

    // The command byte carries the address itself; afterwards the pointer is used.
    assign sel_addr = (state_q == CMD) ? rx_data[6:0] : addr_ptr_q;
    assign in_range = ({1'b0, sel_addr} < NREGS_W);
    assign err_set  = byte_evt && !in_range &&
                      ((state_q == CMD && rx_data[7]) || state_q == WRITE || state_q == READ);

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NREGS; k++) begin
            if (sel_addr == 7'(k)) rd_byte = regs_q[k*8 +: 8];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ss_sync_q      <= '0;
            rdy_sync_q     <= '0;
            fill_q         <= '0;
            rdy_s_dly_q    <= 1'b0;
            armed_q        <= 1'b0;
            addr_ptr_q     <= 7'd0;
            regs_q         <= '0;
            tx_data_q      <= 8'h00;
            tx_latch_q     <= 1'b0;
            lat_pend_q     <= 1'b0;
            wr_strobe_q    <= 1'b0;
            wr_pend_q      <= 1'b0;
            wr_pend_addr_q <= 7'd0;
            wr_addr_q      <= 7'd0;
            addr_err_q     <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], rx_rdy};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            rdy_s_dly_q <= rdy_s;
            wr_pend_q   <= 1'b0;
            lat_pend_q  <= 1'b0;
            wr_strobe_q <= wr_pend_q;
            tx_latch_q  <= lat_pend_q;
            if (wr_pend_q) wr_addr_q <= wr_pend_addr_q;

            // Decoding is only armed once a genuine ss low has been seen after reset,
            // so a frame interrupted by reset is ignored until ss cycles.
            if (!ss_s && fill_q[SYNC_STAGES-1]) armed_q <= 1'b1;

            if (err_clr)      addr_err_q <= 1'b0;
            else if (err_set) addr_err_q <= 1'b1;

            case (state_q)
                IDLE: if (ss_s && armed_q) state_q <= CMD;
                CMD: if (byte_evt) begin
                    if (rx_data[7]) begin
                        tx_data_q  <= rd_byte;
                        lat_pend_q <= 1'b1;
                        addr_ptr_q <= rx_data[6:0] + 7'd1;
                        state_q    <= READ;
                    end else begin
                        addr_ptr_q <= rx_data[6:0];
                        state_q    <= WRITE;
                    end
                end
                WRITE: if (byte_evt) begin
                    if (in_range) begin
                        for (int k = 0; k < NREGS; k++) begin
                            if (addr_ptr_q == 7'(k)) regs_q[k*8 +: 8] <= rx_data;
                        end
                        wr_pend_q      <= 1'b1;
                        wr_pend_addr_q <= addr_ptr_q;
                    end
                    addr_ptr_q <= addr_ptr_q + 7'd1;
                end
                READ: if (byte_evt) begin
                    tx_data_q  <= rd_byte;
                    lat_pend_q <= 1'b1;
                    addr_ptr_q <= addr_ptr_q + 7'd1;
                end
                default: state_q <= IDLE;
            endcase

            if (!ss_s) state_q <= IDLE;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_latch    = tx_latch_q;
    assign reg_out     = regs_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign addr_err    = addr_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed bench for spi_cmd_regs: write/read scoreboards fed at stimulus time, drained by a monitor.
module tb_spi_cmd_regs;
  localparam int NREGS = 16;

  logic               sys_clk = 1'b0;
  logic               rst_n, ss, rx_rdy, err_clr;
  logic [7:0]         rx_data;
  logic [7:0]         tx_data;
  logic               tx_latch, wr_strobe, addr_err;
  logic [NREGS*8-1:0] reg_out;
  logic [6:0]         wr_addr;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int wr_count = 0;
  int w0;

  logic [14:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  model[NREGS];
  logic [14:0] wr_e;
  logic [7:0]  tx_e;
  logic        prev_latch = 1'b0;

  spi_cmd_regs #(.NREGS(NREGS), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ss(ss), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_latch(tx_latch), .reg_out(reg_out), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .addr_err(addr_err), .err_clr(err_clr), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < NREGS; k++) f[k*8 +: 8] = model[k];
    return f;
  endfunction

  // scoreboard monitor, sampled on the falling edge
  always @(negedge sys_clk) begin
    if (wr_strobe === 1'b1) begin
      wr_count++;
      if (exp_wr_q.size() == 0) chk("wr_unexpected", {127'd0, wr_strobe}, 128'd0);
      else begin
        wr_e = exp_wr_q.pop_front();
        chk("wr_addr", {121'd0, wr_addr}, {121'd0, wr_e[14:8]});
        chk("wr_data", {120'd0, reg_out[wr_addr*8 +: 8]}, {120'd0, wr_e[7:0]});
      end
    end
    if (tx_latch === 1'b1) begin
      if (prev_latch) chk("tx_latch_double", {127'd0, prev_latch}, 128'd0);
      if (exp_tx_q.size() == 0) chk("tx_unexpected", {127'd0, tx_latch}, 128'd0);
      else begin
        tx_e = exp_tx_q.pop_front();
        chk("tx_data", {120'd0, tx_data}, {120'd0, tx_e});
      end
    end
    prev_latch = (tx_latch === 1'b1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(6);
    rx_rdy  = 1'b0;
    tick(6);
    chk("wr_q_drained", 128'(exp_wr_q.size()), 128'd0);
    chk("tx_q_drained", 128'(exp_tx_q.size()), 128'd0);
  endtask

  task automatic frame_start();
    ss = 1'b1;
    tick(6);
  endtask

  task automatic frame_end();
    tick(2);
    ss = 1'b0;
    tick(8);
  endtask

  task automatic exp_write(input logic [6:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    model[a[3:0]] = d;
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    rst_n = 1'b0; ss = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; err_clr = 1'b0;

    // reset with ss high and rx_rdy toggling
    repeat (3) begin
      rx_rdy = ~rx_rdy;
      tick(1);
    end
    rx_rdy = 1'b0;
    @(negedge sys_clk);
    chk("rst_reg_out", reg_out, 128'd0);
    chk("rst_addr_err", {127'd0, addr_err}, 128'd0);
    chk("rst_tx_data", {120'd0, tx_data}, 128'd0);
    chk("rst_wr_addr", {121'd0, wr_addr}, 128'd0);
    chk("rst_strobe", {126'd0, wr_strobe, tx_latch}, 128'd0);
    chk("rst_state", {126'd0, dbg_state}, 128'd0);

    // ss still high from before reset: not armed, bytes ignored
    tick(1);
    rst_n = 1'b1;
    tick(4);
    send_byte(8'h07);
    send_byte(8'h12);
    @(negedge sys_clk);
    chk("unarmed_reg_out", reg_out, 128'd0);
    chk("unarmed_state", {126'd0, dbg_state}, 128'd0);
    ss = 1'b0;
    tick(8);

    // single write
    w0 = wr_count;
    frame_start();
    send_byte(8'h03);
    exp_write(7'd3, 8'hA5);
    send_byte(8'hA5);
    frame_end();
    chk("single_reg_out", reg_out, model_flat());
    chk("single_wr_count", 128'(wr_count - w0), 128'd1);
    chk("single_addr_err", {127'd0, addr_err}, 128'd0);

    // burst write running past the last register
    frame_start();
    send_byte(8'h0E);
    exp_write(7'd14, 8'h11);
    send_byte(8'h11);
    exp_write(7'd15, 8'h22);
    send_byte(8'h22);
    send_byte(8'h33);
    frame_end();
    chk("burst_reg_out", reg_out, model_flat());
    chk("burst_addr_err", {127'd0, addr_err}, 128'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge sys_clk);
    chk("err_clr", {127'd0, addr_err}, 128'd0);

    // read burst
    frame_start();
    send_byte(8'h05);
    exp_write(7'd5, 8'h5A);
    send_byte(8'h5A);
    exp_write(7'd6, 8'hC3);
    send_byte(8'hC3);
    frame_end();
    frame_start();
    exp_tx_q.push_back(8'h5A);
    send_byte(8'h85);
    exp_tx_q.push_back(8'hC3);
    send_byte(8'hFF);
    exp_tx_q.push_back(8'h00);
    send_byte(8'hFF);
    frame_end();
    chk("read_reg_out", reg_out, model_flat());
    chk("read_addr_err", {127'd0, addr_err}, 128'd0);

    // read of the last register, then one past the end
    frame_start();
    exp_tx_q.push_back(8'h22);
    send_byte(8'h8F);
    exp_tx_q.push_back(8'h00);
    send_byte(8'h00);
    frame_end();
    chk("read_oob_err", {127'd0, addr_err}, 128'd1);
    chk("read_oob_reg_out", reg_out, model_flat());
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // frame abort, stray byte while deselected, then a fresh frame
    w0 = wr_count;
    frame_start();
    send_byte(8'h02);
    ss = 1'b0;
    tick(8);
    send_byte(8'h55);
    frame_start();
    send_byte(8'h02);
    exp_write(7'd2, 8'h77);
    send_byte(8'h77);
    frame_end();
    chk("abort_reg_out", reg_out, model_flat());
    chk("abort_wr_count", 128'(wr_count - w0), 128'd1);

    // mid-frame reset with ss held high
    frame_start();
    send_byte(8'h01);
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    tick(4);
    send_byte(8'h99);
    @(negedge sys_clk);
    chk("midrst_reg_out", reg_out, 128'd0);
    chk("midrst_state", {126'd0, dbg_state}, 128'd0);
    frame_end();
    frame_start();
    send_byte(8'h01);
    exp_write(7'd1, 8'h99);
    send_byte(8'h99);
    frame_end();
    chk("midrst_after_cycle", reg_out, model_flat());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
